// File: rtl/exc_entry_sequencer.sv
// Exception/interrupt entry and ERET sequencer: serialises EPC/Cause/Status writes over one CP0 port, then redirects fetch.
// Latency: entry 3 writes + redirect (2 + redirect when EXL set); ERET 1 write + redirect; accept pulses in the IDLE cycle.
// Backpressure: requests are not acknowledged while busy; requesters hold them. Optional EXC_SEQ_COUNT_EN adds the entry counter.
module exc_entry_sequencer #(
    parameter logic [31:0] VECTOR      = 32'h8000_0180,
    parameter int          INT_W       = 6,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exc_req,
    input  logic [4:0]       exc_code,
    input  logic [31:0]      exc_epc,
    output logic             exc_ack,
    input  logic [31:0]      int_epc,
    input  logic [INT_W-1:0] hw_int,
    input  logic [INT_W-1:0] int_clr,
    output logic [INT_W-1:0] int_pending,
    input  logic [31:0]      status_in,
    input  logic [31:0]      epc_in,
    input  logic             eret_req,
    output logic             eret_ack,
    output logic             cp0_we,
    output logic [4:0]       cp0_waddr,
    output logic [31:0]      cp0_wdata,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic [31:0]      exc_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_EPC,
        S_W_CAUSE,
        S_W_STATUS,
        S_REDIRECT,
        S_E_STATUS,
        S_E_REDIRECT
    } state_t;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0][INT_W-1:0] sync_q;
    logic [INT_W-1:0]                  sync_prev_q;
    logic [INT_W-1:0]                  pend_q;
    logic [INT_W-1:0]                  int_rise;
    logic [5:0]                        ip6;
    logic                              int_fire;

    logic [4:0]  code_q, cap_code;
    logic [31:0] epc_q, cap_epc;
    logic        cap_en;

    logic        exc_ack_c, eret_ack_c, we_c, redir_c;
    logic [4:0]  waddr_c;
    logic [31:0] wdata_c, rpc_c;

    // Edge detect sits behind the synchronizer so a level held high only sets pending once.
    assign int_rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            sync_prev_q <= '0;
            pend_q      <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], hw_int};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            pend_q      <= (pend_q & ~int_clr) | int_rise;
        end
    end

    generate
        if (INT_W >= 6) begin : g_ip_trunc
            assign ip6 = pend_q[5:0];
        end else begin : g_ip_ext
            assign ip6 = {{(6-INT_W){1'b0}}, pend_q};
        end
    endgenerate

    assign int_fire = (|(ip6 & status_in[15:10])) & status_in[0] & ~status_in[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cap_en) begin
                code_q <= cap_code;
                epc_q  <= cap_epc;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cap_en     = 1'b0;
        cap_code   = '0;
        cap_epc    = '0;
        exc_ack_c  = 1'b0;
        eret_ack_c = 1'b0;
        we_c       = 1'b0;
        waddr_c    = '0;
        wdata_c    = '0;
        redir_c    = 1'b0;
        rpc_c      = '0;
        case (state_q)
            S_IDLE: begin
                // Nested entry (EXL already set) must keep the original EPC.
                if (exc_req) begin
                    exc_ack_c = 1'b1;
                    cap_en    = 1'b1;
                    cap_code  = exc_code;
                    cap_epc   = exc_epc;
                    state_d   = status_in[1] ? S_W_CAUSE : S_W_EPC;
                end else if (int_fire) begin
                    cap_en    = 1'b1;
                    cap_code  = 5'd0;
                    cap_epc   = int_epc;
                    state_d   = status_in[1] ? S_W_CAUSE : S_W_EPC;
                end else if (eret_req) begin
                    eret_ack_c = 1'b1;
                    cap_en     = 1'b1;
                    cap_epc    = epc_in;
                    state_d    = S_E_STATUS;
                end
            end
            S_W_EPC: begin
                we_c    = 1'b1;
                waddr_c = REG_EPC;
                wdata_c = epc_q;
                state_d = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                we_c    = 1'b1;
                waddr_c = REG_CAUSE;
                wdata_c = {16'b0, ip6, 3'b0, code_q, 2'b00};
                state_d = S_W_STATUS;
            end
            S_W_STATUS: begin
                we_c    = 1'b1;
                waddr_c = REG_STATUS;
                wdata_c = status_in | 32'h0000_0002;
                state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                redir_c = 1'b1;
                rpc_c   = VECTOR;
                state_d = S_IDLE;
            end
            S_E_STATUS: begin
                we_c    = 1'b1;
                waddr_c = REG_STATUS;
                wdata_c = status_in & ~32'h0000_0002;
                state_d = S_E_REDIRECT;
            end
            S_E_REDIRECT: begin
                redir_c = 1'b1;
                rpc_c   = epc_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, even before the state register has cleared.
    assign exc_ack     = exc_ack_c & ~reset;
    assign eret_ack    = eret_ack_c & ~reset;
    assign cp0_we      = we_c & ~reset;
    assign cp0_waddr   = reset ? 5'd0 : waddr_c;
    assign cp0_wdata   = reset ? 32'd0 : wdata_c;
    assign pc_redirect = redir_c & ~reset;
    assign redirect_pc = reset ? 32'd0 : rpc_c;
    assign busy        = (state_q != S_IDLE) & ~reset;
    assign int_pending = reset ? '0 : pend_q;

`ifdef EXC_SEQ_COUNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == S_REDIRECT) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign exc_count = reset ? 32'd0 : cnt_q;
`else
    assign exc_count = 32'd0;
`endif

endmodule

// File: tb/tb_exc_entry_sequencer.sv
// Randomized bench for exc_entry_sequencer against a queue-of-operations reference model.
module tb_exc_entry_sequencer;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_ack;
    logic [31:0] int_epc;
    logic [5:0]  hw_int;
    logic [5:0]  int_clr;
    logic [5:0]  int_pending;
    logic [31:0] status_in;
    logic [31:0] epc_in;
    logic        eret_req;
    logic        eret_ack;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [31:0] exc_count;

    exc_entry_sequencer dut (
        .clk(clk), .reset(reset),
        .exc_req(exc_req), .exc_code(exc_code), .exc_epc(exc_epc), .exc_ack(exc_ack),
        .int_epc(int_epc), .hw_int(hw_int), .int_clr(int_clr), .int_pending(int_pending),
        .status_in(status_in), .epc_in(epc_in), .eret_req(eret_req), .eret_ack(eret_ack),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .busy(busy), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    typedef enum int {K_EPC, K_CAUSE, K_SSET, K_SCLR, K_RED_ENTRY, K_RED_ERET} kind_e;
    typedef struct {
        kind_e       k;
        logic [31:0] v;
    } op_t;

    op_t         q[$];
    logic [5:0]  pend_m;
    logic [5:0]  hist[0:S];
    logic [31:0] cnt_m;
    logic        m_exc_ack, m_eret_ack;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_op(input kind_e k, input logic [31:0] v);
        op_t t;
        t.k = k;
        t.v = v;
        q.push_back(t);
    endtask

    task automatic push_entry(input logic [4:0] code, input logic [31:0] epc);
        if (!status_in[1]) push_op(K_EPC, epc);
        push_op(K_CAUSE, {27'd0, code});
        push_op(K_SSET, 32'd0);
        push_op(K_RED_ENTRY, 32'h8000_0180);
    endtask

    // One cycle: compare outputs against the model, advance the model, move to the next negedge.
    task automatic step();
        logic        e_xa, e_ea, e_we, e_red, e_busy, fire;
        logic [4:0]  e_wa;
        logic [31:0] e_wd, e_rpc, e_cnt;
        op_t         op;
        #1;
        e_xa = 0; e_ea = 0; e_we = 0; e_red = 0; e_busy = 0;
        e_wa = 0; e_wd = 0; e_rpc = 0;
        if (!reset) begin
            if (q.size() > 0) begin
                op = q[0];
                e_busy = 1;
                case (op.k)
                    K_EPC:   begin e_we = 1; e_wa = 5'd14; e_wd = op.v; end
                    K_CAUSE: begin e_we = 1; e_wa = 5'd13; e_wd = (32'(pend_m) << 10) | (op.v << 2); end
                    K_SSET:  begin e_we = 1; e_wa = 5'd12; e_wd = status_in | 32'h2; end
                    K_SCLR:  begin e_we = 1; e_wa = 5'd12; e_wd = status_in & ~32'h2; end
                    default: begin e_red = 1; e_rpc = op.v; end
                endcase
            end else begin
                fire = ((pend_m & status_in[15:10]) != 0) && status_in[0] && !status_in[1];
                if (exc_req) begin
                    e_xa = 1;
                    push_entry(exc_code, exc_epc);
                end else if (fire) begin
                    push_entry(5'd0, int_epc);
                end else if (eret_req) begin
                    e_ea = 1;
                    push_op(K_SCLR, 32'd0);
                    push_op(K_RED_ERET, epc_in);
                end
            end
        end
`ifdef EXC_SEQ_COUNT_EN
        e_cnt = reset ? 32'd0 : cnt_m;
`else
        e_cnt = 32'd0;
`endif
        chk("exc_ack", {31'd0, exc_ack}, {31'd0, e_xa});
        chk("eret_ack", {31'd0, eret_ack}, {31'd0, e_ea});
        chk("cp0_we", {31'd0, cp0_we}, {31'd0, e_we});
        chk("cp0_waddr", {27'd0, cp0_waddr}, {27'd0, e_wa});
        chk("cp0_wdata", cp0_wdata, e_wd);
        chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, e_red});
        if (e_red) chk("redirect_pc", redirect_pc, e_rpc);
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("int_pending", {26'd0, int_pending}, reset ? 32'd0 : {26'd0, pend_m});
        chk("exc_count", exc_count, e_cnt);

        if (reset) begin
            q.delete();
            pend_m = 0;
            cnt_m  = 0;
            for (int k = 0; k <= S; k++) hist[k] = 0;
        end else begin
            if (e_busy) begin
                if (q[0].k == K_RED_ENTRY) cnt_m++;
                void'(q.pop_front());
            end
            pend_m = (pend_m & ~int_clr) | (hist[S-1] & ~hist[S]);
            for (int k = S; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = hw_int;
        end
        m_exc_ack  = e_xa;
        m_eret_ack = e_ea;
        @(negedge clk);
        if (m_exc_ack) exc_req = 0;
        if (m_eret_ack) eret_req = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic req_exc(input logic [4:0] code, input logic [31:0] epc);
        exc_req = 1; exc_code = code; exc_epc = epc;
    endtask

    initial begin
        reset = 1; exc_req = 0; exc_code = 0; exc_epc = 0; int_epc = 0;
        hw_int = 0; int_clr = 0; status_in = 0; epc_in = 0; eret_req = 0;
        pend_m = 0; cnt_m = 0; m_exc_ack = 0; m_eret_ack = 0;
        for (int k = 0; k <= S; k++) hist[k] = 0;
        @(negedge clk);
        run(3);
        reset = 0;
        run(2);

        status_in = 32'h0000_FC01; req_exc(5'd12, 32'h0040_0010); run(7);
        status_in = 32'h0000_FC03; req_exc(5'd12, 32'h0040_0010); run(6);

        status_in = 32'h0000_FC03; epc_in = 32'h0040_0024; eret_req = 1; run(4);

        status_in = 32'h0000_FC01; req_exc(5'd4, 32'h0040_0100); eret_req = 1; epc_in = 32'h0040_0200;
        run(10);

        status_in = 32'h0000_FC01; int_epc = 32'h0040_0024; hw_int = 6'b000100; run(12);
        int_clr = 6'h3F; run(1); int_clr = 0; hw_int = 0; run(3);

        status_in = 32'h0000_FC00; hw_int = 6'b001000; run(8);
        status_in = 32'h0000_FC03; run(4);
        int_clr = 6'h3F; run(1); int_clr = 0; hw_int = 0; run(3);

        status_in = 32'h0000_FC01; req_exc(5'd8, 32'h0040_0300); run(2);
        reset = 1; run(1); reset = 0; run(5);

        for (int c = 0; c < 3000; c++) begin
            if (!exc_req && $urandom_range(0, 7) == 0) req_exc(5'($urandom), $urandom);
            if (!eret_req && $urandom_range(0, 7) == 0) eret_req = 1;
            if ($urandom_range(0, 15) == 0) hw_int = hw_int ^ (6'd1 << $urandom_range(0, 5));
            int_clr = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
            status_in = $urandom;
            status_in[0] = ($urandom_range(0, 9) < 7);
            status_in[1] = ($urandom_range(0, 9) < 3);
            int_epc = $urandom;
            epc_in  = $urandom;
            reset   = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exc_entry_sequencer.md
Name: exc_entry_sequencer

Overview:
Multi-cycle sequencer that carries out exception/interrupt entry and ERET return for the multi-cycle CPU.
- Accepts one arbitrated exception request, or a synchronized, masked hardware interrupt.
- Performs the CP0 EPC, Cause and Status writes one per cycle over a single CP0 write port.
- Then issues a one-cycle fetch redirect and pipeline flush.
- Sits between the exception priority logic, the CP0 register file and the Fetch stage.

Parameters:
VECTOR, 32'h8000_0180, general exception entry address (BEV=0)
INT_W, 6, number of hardware interrupt lines
SYNC_STAGES, 2, flop stages in the hw_int synchronizer (minimum 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
exc_req  input  1  arbitrated exception pending; held until exc_ack
exc_code  input  5  ExcCode for Cause[6:2]
exc_epc  input  32  faulting instruction PC
exc_ack  output  1  1-cycle pulse: exception accepted
int_epc  input  32  resume PC used for interrupts
hw_int  input  INT_W  asynchronous interrupt lines
int_clr  input  INT_W  per-bit clear of latched pending
int_pending  output  INT_W  latched pending bits
status_in  input  32  current CP0 Status (IE=bit0, EXL=bit1, IM=bits[15:10])
epc_in  input  32  current CP0 EPC (ERET target)
eret_req  input  1  ERET executing; held until eret_ack
eret_ack  output  1  1-cycle pulse: ERET accepted
cp0_we  output  1  CP0 write enable
cp0_waddr  output  5  CP0 register number (12 Status, 13 Cause, 14 EPC)
cp0_wdata  output  32  CP0 write data
pc_redirect  output  1  1-cycle fetch redirect + pipeline flush
redirect_pc  output  32  redirect target, valid with pc_redirect
busy  output  1  sequencer not in IDLE
exc_count  output  32  taken-entry counter (see Optional Feature)

Behaviour:
- Reset, synchronous, every cycle reset=1:
  - state=IDLE; synchronizer and int_pending cleared.
  - All outputs 0, and exc_count 0.
  - A sequence interrupted by reset is abandoned; no redirect is issued.
- Synchronizer and pending latch:
  - hw_int passes through SYNC_STAGES flops.
  - A rising edge on a synchronized bit sets int_pending[i]; int_clr[i] clears it.
  - Set and clear in the same cycle: set wins.
- int_fire = |(int_pending & status_in[15:10]) & status_in[0] & ~status_in[1]. Evaluated only in IDLE.
- IDLE arbitration: exc_req > int_fire > eret_req. The winner is captured into internal code/epc/target registers.
  - exc_req wins: exc_ack pulses.
  - int_fire wins: code=0, epc=int_epc.
  - eret_req wins: eret_ack pulses.
- Entry path:
  - IDLE -> W_EPC if status_in[1]=0, else W_CAUSE. With EXL already set (nested exception), EPC is not overwritten.
  - W_EPC: cp0_we=1, waddr=14, wdata=captured epc.
  - W_CAUSE: waddr=13, wdata={16'b0, int_pending, 3'b0, code, 2'b00}, where int_pending occupies [15:10] for INT_W=6.
  - W_STATUS: waddr=12, wdata=status_in with bit1 set.
  - REDIRECT: pc_redirect=1, redirect_pc=VECTOR, then IDLE.
- ERET path:
  - E_STATUS: waddr=12, wdata=status_in with bit1 cleared.
  - E_REDIRECT: pc_redirect=1, redirect_pc=captured epc_in, then IDLE.
- Latency, acceptance at cycle 0:
  - Entry: writes in cycles 1-3, redirect in cycle 4. With EXL=1: writes in cycles 1-2, redirect in cycle 3.
  - ERET: write in cycle 1, redirect in cycle 2.
  - busy=1 from cycle 1 through the redirect cycle.
- While busy:
  - exc_req and eret_req are not acknowledged; requesters keep holding them.
  - The pending latch keeps updating.
- cp0_waddr and cp0_wdata are 0 whenever cp0_we=0.
- After REDIRECT/E_REDIRECT the sequencer returns to IDLE. A held request is re-arbitrated on the next cycle.

Optional Feature:
- EXC_SEQ_COUNT_EN defined: exc_count increments by 1, wrapping modulo 2^32, on each entry-path REDIRECT cycle. ERET does not count.
- Not defined: exc_count is tied to 0 and no counter flops exist.

Test Plan:
- exc_req=1, exc_code=12, exc_epc=0x0040_0010, status_in=0x0000_FC01:
  - exc_ack at cycle 0.
  - EPC<=0x0040_0010 at cycle 1, Cause<=0x0000_0030 at cycle 2, Status<=0x0000_FC03 at cycle 3.
  - pc_redirect with 0x8000_0180 at cycle 4.
- Same request with status_in=0x0000_FC03: no EPC write; Cause at cycle 1, Status at cycle 2, redirect at cycle 3.
- hw_int[2] rises, status_in=0x0000_FC01, int_epc=0x0040_0024:
  - int_pending=6'b000100 after SYNC_STAGES+1 cycles.
  - EPC<=0x0040_0024, Cause wdata=0x0000_1000, redirect to 0x8000_0180.
  - With IE=0 or EXL=1: no entry, pending stays set.
- eret_req=1, epc_in=0x0040_0024, status_in=0x0000_FC03: Status<=0x0000_FC01 at cycle 1, redirect to 0x0040_0024 at cycle 2.
- exc_req and eret_req together in IDLE: exception path taken, eret_ack not pulsed. eret accepted the cycle after REDIRECT.
- reset asserted during W_CAUSE: next cycle all outputs 0, busy=0, no pc_redirect ever issued for the aborted entry.
